// File: rtl/spi_target_if.sv
// CPU-side register window of the SPI target: address, write/read strobes and data.
// The CPU drives the master modport; spi_target sits on the slave modport.
interface spi_target_if;
  logic [2:0] reg_addr;
  logic [7:0] reg_data_in;
  logic [7:0] reg_data_out;
  logic       reg_read;
  logic       reg_write;

  modport master (output reg_addr, reg_data_in, reg_read, reg_write, input reg_data_out);
  modport slave  (input reg_addr, reg_data_in, reg_read, reg_write, output reg_data_out);
endinterface

// File: rtl/spi_target.sv
// SPI target: synchronises the host pins into clk, shifts 8-bit frames in all four modes,
// and double-buffers RX/TX bytes behind an 8-bit register window with a level interrupt.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hff
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic interrupt,
  spi_target_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int ST_RX = 0, ST_TX = 1, ST_OVR = 2, ST_UND = 3, ST_END = 4;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_prev, cs_prev;

  // cs is reset to "selected" so a host still holding cs_n low after reset does not look like a new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  sh_tx_reg, sh_tx_next;
  logic [6:0]  sh_rx_reg, sh_rx_next;
  logic        need_load_reg, need_load_next;
  logic        cpol_reg, cpol_next, cpha_reg, cpha_next;
  logic        miso_reg, miso_next, miso_oe_reg, miso_oe_next;
  logic [7:0]  rx_hold_reg, rx_hold_next, tx_hold_reg, tx_hold_next;
  logic        rx_full_reg, rx_full_next, tx_full_reg, tx_full_next;
  logic [4:0]  int_status_reg, int_status_next, int_enable_reg, int_enable_next;
  logic [1:0]  mode_reg, mode_next;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, lead, trail, sample, drive;
  logic rd_rx, wr_tx, wr_int, wr_cfg, load;
  logic [4:0] set_mask, w1c_mask;
  logic [7:0] load_byte, rx_byte;

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign lead      = cpol_reg ? sclk_fall : sclk_rise;
  assign trail     = cpol_reg ? sclk_rise : sclk_fall;
  assign sample    = cpha_reg ? trail : lead;
  assign drive     = cpha_reg ? lead : trail;

  assign rd_rx    = bus.reg_read  && (bus.reg_addr == 3'd0);
  assign wr_tx    = bus.reg_write && (bus.reg_addr == 3'd0);
  assign wr_int   = bus.reg_write && (bus.reg_addr == 3'd2);
  assign wr_cfg   = bus.reg_write && (bus.reg_addr == 3'd3);
  assign w1c_mask = wr_int ? bus.reg_data_in[4:0] : 5'd0;

  assign load_byte = tx_full_reg ? tx_hold_reg : IDLE_BYTE;
  assign rx_byte   = {sh_rx_reg, mosi_s};

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    sh_tx_next      = sh_tx_reg;
    sh_rx_next      = sh_rx_reg;
    need_load_next  = need_load_reg;
    cpol_next       = cpol_reg;
    cpha_next       = cpha_reg;
    miso_next       = miso_reg;
    rx_hold_next    = rx_hold_reg;
    rx_full_next    = rx_full_reg;
    tx_hold_next    = tx_hold_reg;
    tx_full_next    = tx_full_reg;
    int_enable_next = int_enable_reg;
    mode_next       = mode_reg;
    set_mask        = '0;
    load            = 1'b0;

    if (rd_rx) rx_full_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next     = ACTIVE;
          bit_cnt_next   = '0;
          need_load_next = 1'b0;
          cpol_next      = mode_reg[1];
          cpha_next      = mode_reg[0];
          load           = 1'b1;
          sh_tx_next     = load_byte;
          if (!mode_reg[0]) miso_next = load_byte[7];
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next           = IDLE;
          bit_cnt_next         = '0;
          need_load_next       = 1'b0;
          set_mask[ST_END]     = 1'b1;
        end else begin
          if (sample) begin
            sh_rx_next = rx_byte[6:0];
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next     = '0;
              need_load_next   = 1'b1;
              set_mask[ST_RX]  = 1'b1;
              // a read in this same clk frees the buffer, so the new byte is not an overrun
              if (rx_full_reg && !rd_rx) begin
                set_mask[ST_OVR] = 1'b1;
              end else begin
                rx_hold_next = rx_byte;
                rx_full_next = 1'b1;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
          if (drive) begin
            if (need_load_reg) begin
              load           = 1'b1;
              need_load_next = 1'b0;
              miso_next      = load_byte[7];
              sh_tx_next     = cpha_reg ? {load_byte[6:0], 1'b0} : load_byte;
            end else begin
              miso_next  = cpha_reg ? sh_tx_reg[7] : sh_tx_reg[6];
              sh_tx_next = {sh_tx_reg[6:0], 1'b0};
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      if (tx_full_reg) begin
        tx_full_next    = 1'b0;
        set_mask[ST_TX] = 1'b1;
      end else begin
        set_mask[ST_UND] = 1'b1;
      end
    end
    if (wr_tx) begin
      tx_hold_next = bus.reg_data_in;
      tx_full_next = 1'b1;
    end
    if (wr_cfg) begin
      int_enable_next = bus.reg_data_in[6:2];
      mode_next       = bus.reg_data_in[1:0];
    end

    int_status_next = (int_status_reg & ~w1c_mask) | set_mask;
    miso_oe_next    = (state_next == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      sh_tx_reg      <= '0;
      sh_rx_reg      <= '0;
      need_load_reg  <= 1'b0;
      cpol_reg       <= 1'b0;
      cpha_reg       <= 1'b0;
      miso_reg       <= 1'b0;
      miso_oe_reg    <= 1'b0;
      rx_hold_reg    <= '0;
      rx_full_reg    <= 1'b0;
      tx_hold_reg    <= '0;
      tx_full_reg    <= 1'b0;
      int_status_reg <= '0;
      int_enable_reg <= '0;
      mode_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      sh_tx_reg      <= sh_tx_next;
      sh_rx_reg      <= sh_rx_next;
      need_load_reg  <= need_load_next;
      cpol_reg       <= cpol_next;
      cpha_reg       <= cpha_next;
      miso_reg       <= miso_next;
      miso_oe_reg    <= miso_oe_next;
      rx_hold_reg    <= rx_hold_next;
      rx_full_reg    <= rx_full_next;
      tx_hold_reg    <= tx_hold_next;
      tx_full_reg    <= tx_full_next;
      int_status_reg <= int_status_next;
      int_enable_reg <= int_enable_next;
      mode_reg       <= mode_next;
    end
  end

  assign miso      = miso_reg;
  assign miso_oe   = miso_oe_reg;
  assign interrupt = |(int_status_reg & int_enable_reg);

  always_comb begin
    unique case (bus.reg_addr)
      3'd0:    bus.reg_data_out = rx_hold_reg;
      3'd1:    bus.reg_data_out = {4'b0, ~cs_s, tx_full_reg, rx_full_reg, (bit_cnt_reg != 3'd0)};
      3'd2:    bus.reg_data_out = {3'b0, int_status_reg};
      3'd3:    bus.reg_data_out = {1'b0, int_enable_reg, mode_reg};
      default: bus.reg_data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: register-level host model driving SPI frames, with a vector table,
// hand-written corner sequences and a randomized byte-level reference model.
module tb_spi_target;
  localparam int H = 8;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic reset, sclk, cs_n, mosi, miso, miso_oe, interrupt;
  spi_target_if bus();

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hff)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .interrupt(interrupt), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] mode;
    logic       refill_en;
    logic [7:0] refill;
    logic [7:0] tx;
    logic [7:0] host_tx;
    logic [7:0] exp_miso;
    logic [7:0] exp_mid;
    logic [7:0] exp_end;
  } vec_t;
  vec_t vecs[5];

  // byte-level reference state
  logic [7:0] m_tx_hold, m_rx_hold;
  logic       m_tx_full, m_rx_full;
  logic [4:0] m_st;

  logic [7:0] d, got, cur, h, v;
  logic [7:0] g0, g1, g2;
  logic [1:0] md;
  int nfull, part, nslots, nb;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] dat);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_data_in = dat; bus.reg_write = 1'b1;
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] dat);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_read = 1'b1;
    #1 dat = bus.reg_data_out;
    @(negedge clk);
    bus.reg_read = 1'b0;
  endtask

  task automatic cs_low(input logic [1:0] mode);
    sclk = mode[1];
    wait_clk(H);
    cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    cs_n = 1'b1;
    wait_clk(2 * H);
  endtask

  // Host side: sends the top nbits of dat MSB first, returns the bits seen on miso.
  task automatic spi_bits(input logic [1:0] mode, input logic [7:0] dat, input int nbits,
                          output logic [7:0] rcv);
    rcv = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!mode[0]) begin
        mosi = dat[7-i];
        wait_clk(H);
        sclk = ~mode[1];
        rcv = {rcv[6:0], miso};
        wait_clk(H);
        sclk = mode[1];
      end else begin
        sclk = ~mode[1];
        mosi = dat[7-i];
        wait_clk(H);
        sclk = mode[1];
        rcv = {rcv[6:0], miso};
        wait_clk(H);
      end
    end
  endtask

  task automatic m_load(output logic [7:0] b);
    if (m_tx_full) begin
      b = m_tx_hold; m_tx_full = 1'b0; m_st[1] = 1'b1;
    end else begin
      b = 8'hff; m_st[3] = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 1'b1, 8'h5a, 8'ha5, 8'h3c, 8'ha5, 8'h03, 8'h13};
    vecs[1] = '{2'd1, 1'b0, 8'h00, 8'h81, 8'h7e, 8'h81, 8'h03, 8'h13};
    vecs[2] = '{2'd2, 1'b0, 8'h00, 8'h81, 8'h7e, 8'h81, 8'h0b, 8'h1b};
    vecs[3] = '{2'd3, 1'b0, 8'h00, 8'h81, 8'h7e, 8'h81, 8'h03, 8'h13};
    vecs[4] = '{2'd0, 1'b0, 8'h00, 8'h81, 8'h7e, 8'h81, 8'h0b, 8'h1b};

    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    bus.reg_addr = 3'd0; bus.reg_data_in = 8'h00; bus.reg_read = 1'b0; bus.reg_write = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(6);

    check("reset miso", {7'b0, miso}, 8'h00);
    check("reset miso_oe", {7'b0, miso_oe}, 8'h00);
    check("reset interrupt", {7'b0, interrupt}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      reg_rd(3'(a), d);
      check($sformatf("reset reg%0d", a), d, 8'h00);
    end

    // vector table: one single-byte frame per row
    for (int r = 0; r < 5; r++) begin
      reg_rd(0, d);
      reg_wr(2, 8'h1f);
      reg_wr(3, 8'h7c | {6'b0, vecs[r].mode});
      reg_wr(0, vecs[r].tx);
      cs_low(vecs[r].mode);
      check($sformatf("row%0d miso_oe", r), {7'b0, miso_oe}, 8'h01);
      if (vecs[r].refill_en) reg_wr(0, vecs[r].refill);
      spi_bits(vecs[r].mode, vecs[r].host_tx, 8, got);
      wait_clk(H);
      check($sformatf("row%0d host rx", r), got, vecs[r].exp_miso);
      reg_rd(2, d);
      check($sformatf("row%0d status mid", r), d, vecs[r].exp_mid);
      cs_high();
      reg_rd(2, d);
      check($sformatf("row%0d status end", r), d, vecs[r].exp_end);
      check($sformatf("row%0d interrupt", r), {7'b0, interrupt}, 8'h01);
      reg_rd(0, d);
      check($sformatf("row%0d rx_hold", r), d, vecs[r].host_tx);
      $display("row %0d mode=%0d host_rx=%02h", r, vecs[r].mode, got);
    end

    // three-byte frame, tx refilled once: third byte falls back to the idle byte
    reg_wr(2, 8'h1f); reg_wr(3, 8'h00); reg_wr(0, 8'h11);
    cs_low(2'd0);
    reg_wr(0, 8'h22);
    spi_bits(2'd0, 8'h01, 8, g0);
    spi_bits(2'd0, 8'h02, 8, g1);
    spi_bits(2'd0, 8'h03, 8, g2);
    cs_high();
    check("refill byte0", g0, 8'h11);
    check("refill byte1", g1, 8'h22);
    check("refill byte2", g2, 8'hff);
    reg_rd(2, d);
    check("refill und", d & 8'h08, 8'h08);
    $display("refill frame host_rx=%02h %02h %02h", g0, g1, g2);

    // overrun: two bytes with no rx read, only ovr enabled
    reg_rd(0, d); reg_wr(2, 8'h1f); reg_wr(3, 8'h10);
    cs_low(2'd0);
    spi_bits(2'd0, 8'h55, 8, got);
    spi_bits(2'd0, 8'haa, 8, got);
    cs_high();
    check("ovr interrupt", {7'b0, interrupt}, 8'h01);
    reg_rd(0, d);
    check("ovr rx_hold", d, 8'h55);
    reg_rd(2, d);
    check("ovr flag", d & 8'h04, 8'h04);
    reg_wr(2, 8'h04);
    check("ovr cleared interrupt", {7'b0, interrupt}, 8'h00);

    // abort after 4 bits, then a full byte must realign
    reg_rd(0, d); reg_wr(2, 8'h1f); reg_wr(3, 8'h00);
    cs_low(2'd0);
    spi_bits(2'd0, 8'hf0, 4, got);
    cs_high();
    reg_rd(1, d);
    check("abort reg1", d, 8'h00);
    reg_rd(2, d);
    check("abort end/rx", d & 8'h11, 8'h10);
    cs_low(2'd0);
    spi_bits(2'd0, 8'h96, 8, got);
    cs_high();
    reg_rd(0, d);
    check("abort realign", d, 8'h96);

    // W1C of rx held across the clk where the 8th sample lands (pin edge + 3 clk)
    reg_wr(2, 8'h1f);
    cs_low(2'd0);
    spi_bits(2'd0, 8'hc3, 7, got);
    mosi = 1'b1;
    wait_clk(H);
    sclk = 1'b1;
    bus.reg_addr = 3'd2; bus.reg_data_in = 8'h01; bus.reg_write = 1'b1;
    wait_clk(3);
    bus.reg_write = 1'b0;
    wait_clk(H);
    sclk = 1'b0;
    reg_rd(2, d);
    check("w1c vs set rx", d & 8'h01, 8'h01);
    cs_high();
    reg_rd(0, d);
    check("w1c rx_hold", d, 8'hc3);

    // reset in the middle of a byte
    reg_wr(3, 8'h7c); reg_wr(0, 8'h3c);
    cs_low(2'd0);
    spi_bits(2'd0, 8'ha5, 4, got);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("midreset miso_oe", {7'b0, miso_oe}, 8'h00);
    check("midreset interrupt", {7'b0, interrupt}, 8'h00);
    reg_rd(2, d);
    check("midreset status", d, 8'h00);
    reg_rd(1, d);
    check("midreset flags", d & 8'h07, 8'h00);
    reg_rd(3, d);
    check("midreset cfg", d, 8'h00);
    cs_n = 1'b1;
    wait_clk(2 * H);

    // randomized frames against the byte-level model
    m_tx_hold = 8'h00; m_rx_hold = 8'h00; m_tx_full = 1'b0; m_rx_full = 1'b0; m_st = 5'h00;
    for (int it = 0; it < 24; it++) begin
      md = 2'($urandom_range(0, 3));
      reg_wr(3, {1'b0, 5'h1f, md});
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom); reg_wr(0, v); m_tx_hold = v; m_tx_full = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        reg_rd(0, d); check("rand rx_hold", d, m_rx_hold); m_rx_full = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        v = 8'($urandom); reg_wr(2, v); m_st = m_st & ~v[4:0];
      end
      nfull = $urandom_range(1, 3);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      nslots = nfull + ((part != 0) ? 1 : 0);
      cs_low(md);
      m_load(cur);
      for (int k = 0; k < nslots; k++) begin
        nb = (k < nfull) ? 8 : part;
        if (k > 0 && md[0]) m_load(cur);
        h = 8'($urandom);
        spi_bits(md, h, nb, got);
        check("rand host rx", got, 8'(cur >> (8 - nb)));
        if (nb == 8) begin
          m_st[0] = 1'b1;
          if (m_rx_full) m_st[2] = 1'b1;
          else begin m_rx_hold = h; m_rx_full = 1'b1; end
          if (!md[0]) m_load(cur);
        end
      end
      cs_high();
      m_st[4] = 1'b1;
      reg_rd(2, d);
      check("rand status", d, {3'b0, m_st});
      reg_rd(1, d);
      check("rand reg1", d, {5'b0, m_tx_full, m_rx_full, 1'b0});
      check("rand interrupt", {7'b0, interrupt}, {7'b0, |m_st});
      $display("rand %0d mode=%0d bytes=%0d partial=%0d status=%02h", it, md, nfull, part, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
